// File: rtl/uart_tx_fifo.sv
// Byte FIFO and pacing controller that feeds a UART transmitter one byte at a time,
// issuing the next DV strobe only once the transmitter has returned to its idle state.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_L,
    input  logic                  i_Wr_DV,
    input  logic [7:0]            i_Wr_Byte,
    output logic                  o_Full,
    output logic                  o_Empty,
    output logic [DEPTH_LOG2:0]   o_Count,
    output logic                  o_Overflow,
    output logic                  o_Busy,
    output logic                  o_Tx_DV,
    output logic [7:0]            o_Tx_Byte,
    input  logic                  i_Tx_Active,
    input  logic                  i_Tx_Done
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_IDLE  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_COOL  = 3'd4
    } state_t;

    state_t                  r_State;
    logic [7:0]              r_Mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_Wr_Ptr;
    logic [DEPTH_LOG2-1:0]   r_Rd_Ptr;
    logic                    w_Push;
    logic                    w_Pop;
    logic [DEPTH_LOG2:0]     w_Next_Count;
    logic                    w_Next_Empty;

    // Pops are decided from registered flags only, so a fresh byte waits one edge.
    assign w_Push       = i_Wr_DV & ~o_Full;
    assign w_Pop        = (r_State == S_IDLE) & ~o_Empty;
    assign w_Next_Empty = (w_Next_Count == CNT_ZERO);

    // Occupancy after this edge's push/pop
    always_comb begin
        w_Next_Count = o_Count;
        case ({w_Push, w_Pop})
            2'b10:   w_Next_Count = o_Count + CNT_ONE;
            2'b01:   w_Next_Count = o_Count - CNT_ONE;
            default: w_Next_Count = o_Count;
        endcase
    end

    // Storage array; contents need no reset since pointers gate every read
    always_ff @(posedge i_Clock) begin
        if (w_Push) begin
            r_Mem[r_Wr_Ptr] <= i_Wr_Byte;
        end
    end

    // Pointers, count and status flags
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            r_Wr_Ptr   <= '0;
            r_Rd_Ptr   <= '0;
            o_Count    <= CNT_ZERO;
            o_Empty    <= 1'b1;
            o_Full     <= 1'b0;
            o_Overflow <= 1'b0;
        end else begin
            if (w_Push) begin
                r_Wr_Ptr <= r_Wr_Ptr + PTR_ONE;
            end else begin
                r_Wr_Ptr <= r_Wr_Ptr;
            end
            if (w_Pop) begin
                r_Rd_Ptr <= r_Rd_Ptr + PTR_ONE;
            end else begin
                r_Rd_Ptr <= r_Rd_Ptr;
            end
            o_Count    <= w_Next_Count;
            o_Empty    <= w_Next_Empty;
            o_Full     <= (w_Next_Count == CNT_FULL);
            o_Overflow <= i_Wr_DV & o_Full;
        end
    end

    // Pacing FSM: one DV per frame, next one only after Done has fallen again
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            r_State   <= S_SYNC;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= 8'h00;
            o_Busy    <= 1'b1;
        end else begin
            o_Tx_DV <= 1'b0;
            case (r_State)
                S_SYNC: begin
                    // The transmitter is never reset; let any frame in flight finish.
                    if (!i_Tx_Active && !i_Tx_Done) begin
                        r_State <= S_IDLE;
                        o_Busy  <= ~w_Next_Empty;
                    end else begin
                        r_State <= S_SYNC;
                        o_Busy  <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!o_Empty) begin
                        o_Tx_Byte <= r_Mem[r_Rd_Ptr];
                        o_Tx_DV   <= 1'b1;
                        r_State   <= S_START;
                        o_Busy    <= 1'b1;
                    end else begin
                        r_State <= S_IDLE;
                        o_Busy  <= ~w_Next_Empty;
                    end
                end
                S_START: begin
                    o_Busy <= 1'b1;
                    if (i_Tx_Active) begin
                        r_State <= S_WAIT;
                    end else begin
                        r_State <= S_START;
                    end
                end
                S_WAIT: begin
                    o_Busy <= 1'b1;
                    if (i_Tx_Done) begin
                        r_State <= S_COOL;
                    end else begin
                        r_State <= S_WAIT;
                    end
                end
                S_COOL: begin
                    if (!i_Tx_Done) begin
                        r_State <= S_IDLE;
                        o_Busy  <= ~w_Next_Empty;
                    end else begin
                        r_State <= S_COOL;
                        o_Busy  <= 1'b1;
                    end
                end
                default: begin
                    r_State <= S_SYNC;
                    o_Busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: drives it with a behavioural UART transmitter, decodes the
// serial line, and checks every cycle against a queue-based model of the FIFO and pacing rules.
module tb_uart_tx_fifo;

    localparam int DL    = 2;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_l   = 1'b0;
    logic        wr_dv   = 1'b0;
    logic [7:0]  wr_byte = 8'h00;
    logic        o_full, o_empty, o_ovf, o_busy, o_tx_dv;
    logic [DL:0] o_count;
    logic [7:0]  o_tx_byte;

    // Transmitter model (no reset, Done high for two cycles per frame)
    typedef enum int {T_IDLE, T_START, T_DATA, T_STOP, T_CLEAN} tx_st_t;
    tx_st_t     tx_st     = T_IDLE;
    int         tx_cnt    = 0;
    int         tx_bit    = 0;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_serial = 1'b1;
    logic       tx_active = 1'b0;
    logic       tx_done   = 1'b0;

    uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
        .i_Clock(clk), .i_Rst_L(rst_l), .i_Wr_DV(wr_dv), .i_Wr_Byte(wr_byte),
        .o_Full(o_full), .o_Empty(o_empty), .o_Count(o_count), .o_Overflow(o_ovf),
        .o_Busy(o_busy), .o_Tx_DV(o_tx_dv), .o_Tx_Byte(o_tx_byte),
        .i_Tx_Active(tx_active), .i_Tx_Done(tx_done)
    );

    always @(posedge clk) begin
        case (tx_st)
            T_IDLE: begin
                tx_serial <= 1'b1; tx_done <= 1'b0; tx_cnt <= 0; tx_bit <= 0;
                if (o_tx_dv) begin
                    tx_data <= o_tx_byte; tx_active <= 1'b1; tx_st <= T_START;
                end
            end
            T_START: begin
                tx_serial <= 1'b0;
                if (tx_cnt < CPB - 1) tx_cnt <= tx_cnt + 1;
                else begin tx_cnt <= 0; tx_st <= T_DATA; end
            end
            T_DATA: begin
                tx_serial <= tx_data[tx_bit];
                if (tx_cnt < CPB - 1) tx_cnt <= tx_cnt + 1;
                else begin
                    tx_cnt <= 0;
                    if (tx_bit < 7) tx_bit <= tx_bit + 1;
                    else begin tx_bit <= 0; tx_st <= T_STOP; end
                end
            end
            T_STOP: begin
                tx_serial <= 1'b1;
                if (tx_cnt < CPB - 1) tx_cnt <= tx_cnt + 1;
                else begin tx_done <= 1'b1; tx_cnt <= 0; tx_active <= 1'b0; tx_st <= T_CLEAN; end
            end
            default: begin
                tx_done <= 1'b1; tx_st <= T_IDLE;
            end
        endcase
    end

    int n_checks = 0;
    int n_err    = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endfunction

    // Model: stored bytes as a queue; controller "free" once the transmitter has
    // finished a frame (Done seen, then low) or, after reset, is seen quiet.
    logic [7:0] mq[$];
    bit         m_valid = 1'b0;
    bit         m_free, m_sync, m_saw_done, m_pop, m_push;
    int         m_cnt;
    bit         e_dv, e_ovf, e_busy;
    logic [7:0] e_byte;
    int         cyc = 0;
    int         n_frames = 0;
    bit         done_q = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (tx_done && !done_q) n_frames++;
        done_q = tx_done;
        if (!rst_l) begin
            mq.delete();
            m_free = 1'b0; m_sync = 1'b1; m_saw_done = 1'b0;
            e_dv = 1'b0; e_byte = 8'h00; e_ovf = 1'b0; e_busy = 1'b1;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_cnt  = mq.size();
            m_pop  = m_free && (m_cnt > 0);
            m_push = wr_dv && (m_cnt < DEPTH);
            e_ovf  = wr_dv && (m_cnt == DEPTH);
            e_dv   = m_pop;
            if (m_pop) begin
                e_byte = mq.pop_front();
                m_free = 1'b0; m_sync = 1'b0; m_saw_done = 1'b0;
            end else if (!m_free) begin
                if ((m_sync && !tx_active && !tx_done) || (m_saw_done && !tx_done)) begin
                    m_free = 1'b1; m_sync = 1'b0;
                end
                if (tx_done) m_saw_done = 1'b1;
            end
            if (m_push) mq.push_back(wr_byte);
            e_busy = !(m_free && mq.size() == 0);
        end
    end

    // Per-cycle comparison against the model, plus DV protocol rules
    int n_dv = 0;
    int dv_times[$];
    bit prev_dv = 1'b0;
    always @(negedge clk) begin
        if (m_valid) begin
            chk("count",   int'(o_count), mq.size());
            chk("empty",   int'(o_empty), int'(mq.size() == 0));
            chk("full",    int'(o_full),  int'(mq.size() == DEPTH));
            chk("ovf",     int'(o_ovf),   int'(e_ovf));
            chk("busy",    int'(o_busy),  int'(e_busy));
            chk("tx_dv",   int'(o_tx_dv), int'(e_dv));
            chk("tx_byte", int'(o_tx_byte), int'(e_byte));
            if (o_tx_dv) begin
                n_dv++;
                dv_times.push_back(cyc);
                chk("dv_tx_idle", int'({tx_active, tx_done}), 0);
                chk("dv_back2back", int'(prev_dv), 0);
            end
            prev_dv = o_tx_dv;
        end
    end

    // Serial line decoder sampling mid-bit
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = 8'h00;
    bit         rx_busy = 1'b0;
    int         rx_k = 0;
    always @(negedge clk) begin
        if (!rx_busy) begin
            if (tx_serial == 1'b0) begin rx_busy = 1'b1; rx_k = 0; end
        end else begin
            rx_k++;
        end
        if (rx_busy) begin
            if (rx_k == 2) chk("start_bit", int'(tx_serial), 0);
            if (rx_k >= 6 && rx_k <= 34 && ((rx_k - 2) % 4) == 0) rx_sh[(rx_k - 6) / 4] = tx_serial;
            if (rx_k == 38) begin
                chk("stop_bit", int'(tx_serial), 1);
                rx_q.push_back(rx_sh);
                rx_busy = 1'b0;
            end
        end
    end

    task automatic wr(input logic [7:0] b);
        wr_dv = 1'b1; wr_byte = b;
        @(negedge clk);
        wr_dv = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!(o_busy == 1'b0 && tx_st == T_IDLE && !tx_done && !rx_busy) && t < 2000) begin
            @(negedge clk); t++;
        end
        chk("idle_timeout", int'(t < 2000), 1);
    endtask

    task automatic chk_rx(input string nm, input logic [7:0] exp[$]);
        chk({nm, "_len"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) chk(nm, int'(rx_q[i]), int'(exp[i]));
    endtask

    initial begin
        int t;
        int dv_before;
        // Reset state
        @(negedge clk);
        chk("rst_empty", int'(o_empty), 1);
        chk("rst_full",  int'(o_full), 0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_dv",    int'(o_tx_dv), 0);
        chk("rst_byte",  int'(o_tx_byte), 8'h00);
        chk("rst_busy",  int'(o_busy), 1);
        rst_l = 1'b1;
        @(negedge clk);
        chk("sync_exit_busy", int'(o_busy), 0);

        // 1: single byte, DV one cycle after the write edge
        rx_q.delete();
        wr(8'hA5);
        chk("t1_dv_early", int'(o_tx_dv), 0);
        chk("t1_count1",   int'(o_count), 1);
        @(negedge clk);
        chk("t1_dv",    int'(o_tx_dv), 1);
        chk("t1_byte",  int'(o_tx_byte), 8'hA5);
        chk("t1_empty", int'(o_empty), 1);
        wait_idle();
        chk_rx("t1_rx", '{8'hA5});

        // 2: burst of five, depth four
        rx_q.delete(); dv_times.delete();
        for (int i = 1; i <= 5; i++) wr(8'(i));
        chk("t2_peak", int'(o_count), 4);
        chk("t2_full", int'(o_full), 1);
        wait_idle();
        chk_rx("t2_rx", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        chk("t2_ndv", dv_times.size(), 5);
        for (int i = 1; i < dv_times.size(); i++) chk("t2_dv_period", dv_times[i] - dv_times[i-1], 45);

        // 3: overflow while the transmitter is busy
        rx_q.delete();
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44); wr(8'h55);
        chk("t3_count4", int'(o_count), 4);
        chk("t3_ovf_pre", int'(o_ovf), 0);
        wr(8'hFF);
        chk("t3_ovf", int'(o_ovf), 1);
        chk("t3_count_hold", int'(o_count), 4);
        @(negedge clk);
        chk("t3_ovf_pulse", int'(o_ovf), 0);
        wait_idle();
        chk_rx("t3_rx", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});

        // 4: push and pop on the same edge with two stored
        rx_q.delete();
        wr(8'h66); wr(8'h77); wr(8'h88);
        chk("t4_count2", int'(o_count), 2);
        t = 0;
        while (!(m_free && mq.size() > 0) && t < 500) begin @(negedge clk); t++; end
        chk("t4_pop_timeout", int'(t < 500), 1);
        wr(8'h99);
        chk("t4_count_same", int'(o_count), 2);
        chk("t4_dv",    int'(o_tx_dv), 1);
        chk("t4_byte",  int'(o_tx_byte), 8'h77);
        chk("t4_empty", int'(o_empty), 0);
        chk("t4_full",  int'(o_full), 0);
        wait_idle();
        chk_rx("t4_rx", '{8'h66, 8'h77, 8'h88, 8'h99});

        // 5: reset during data bit 3 with two bytes queued
        rx_q.delete();
        wr(8'h3C); wr(8'hAA); wr(8'hBB);
        t = 0;
        while (!(tx_st == T_DATA && tx_bit == 3) && t < 500) begin @(negedge clk); t++; end
        chk("t5_bit3_timeout", int'(t < 500), 1);
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        chk("t5_count", int'(o_count), 0);
        chk("t5_empty", int'(o_empty), 1);
        chk("t5_busy",  int'(o_busy), 1);
        dv_before = n_dv;
        wait_idle();
        chk("t5_no_dv", n_dv, dv_before);
        chk_rx("t5_rx", '{8'h3C});
        wr(8'h5A);
        wait_idle();
        chk_rx("t5_rx_after", '{8'h3C, 8'h5A});

        // 6: one DV per completed frame overall
        chk("t6_dv_per_frame", n_dv, n_frames);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
